// File: rtl/regarray_2r1w_32x32_sdr.sv
// regarray_2r1w_32x32_sdr
//   32 x 32-bit register array with two read ports and one write port.
//   All ports are sampled on the rising edge of clk. Each read port registers
//   its enable and address. Its data is then decoded combinationally from the
//   current array contents. A write and a read sampled on the same edge at the
//   same address therefore return the new word, with no bypass mux needed.
//   Optional build macro: STROBE_GATE_EN. When it is defined, a write also
//   needs strobe==1. When it is undefined, strobe is ignored.
module regarray_2r1w_32x32_sdr #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe,
    input  logic              rd_enb_0,
    input  logic [ADDR_W-1:0] rd_adr_0,
    output logic [DATA_W-1:0] rd_dat_0,
    input  logic              rd_enb_1,
    input  logic [ADDR_W-1:0] rd_adr_1,
    output logic [DATA_W-1:0] rd_dat_1,
    input  logic              wr_enb_0,
    input  logic [ADDR_W-1:0] wr_adr_0,
    input  logic [DATA_W-1:0] wr_dat_0
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_commit;

    logic              rd_vld_0_p1;
    logic [ADDR_W-1:0] rd_adr_0_p1;
    logic              rd_vld_1_p1;
    logic [ADDR_W-1:0] rd_adr_1_p1;

`ifdef STROBE_GATE_EN
    assign wr_commit = wr_enb_0 & strobe;
`else
    logic unused_strobe;
    assign unused_strobe = strobe;
    assign wr_commit     = wr_enb_0;
`endif

    // Array storage: the whole array clears on reset; otherwise one word is written per edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_commit) begin
            mem[wr_adr_0] <= wr_dat_0;
        end
    end

    // ---- stage p0 -> p1: sample the read enables and addresses ----
    // Register each read port's enable and address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_0_p1 <= 1'b0;
            rd_adr_0_p1 <= '0;
            rd_vld_1_p1 <= 1'b0;
            rd_adr_1_p1 <= '0;
        end else begin
            rd_vld_0_p1 <= rd_enb_0;
            rd_adr_0_p1 <= rd_adr_0;
            rd_vld_1_p1 <= rd_enb_1;
            rd_adr_1_p1 <= rd_adr_1;
        end
    end

    // ---- stage p1: decode the read data from the current array contents ----
    // A disabled port drives zero instead of holding the previous word
    always_comb begin
        rd_dat_0 = '0;
        rd_dat_1 = '0;
        if (rd_vld_0_p1) begin
            rd_dat_0 = mem[rd_adr_0_p1];
        end
        if (rd_vld_1_p1) begin
            rd_dat_1 = mem[rd_adr_1_p1];
        end
    end

endmodule

// File: tb/tb_regarray_2r1w_32x32_sdr.sv
// Directed testbench for regarray_2r1w_32x32_sdr
module tb_regarray_2r1w_32x32_sdr;

    logic        clk;
    logic        reset;
    logic        strobe;
    logic        rd_enb_0;
    logic [4:0]  rd_adr_0;
    logic [31:0] rd_dat_0;
    logic        rd_enb_1;
    logic [4:0]  rd_adr_1;
    logic [31:0] rd_dat_1;
    logic        wr_enb_0;
    logic [4:0]  wr_adr_0;
    logic [31:0] wr_dat_0;

    int checks = 0;
    int errors = 0;

    regarray_2r1w_32x32_sdr #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .strobe   (strobe),
        .rd_enb_0 (rd_enb_0),
        .rd_adr_0 (rd_adr_0),
        .rd_dat_0 (rd_dat_0),
        .rd_enb_1 (rd_enb_1),
        .rd_adr_1 (rd_adr_1),
        .rd_dat_1 (rd_dat_1),
        .wr_enb_0 (wr_enb_0),
        .wr_adr_0 (wr_adr_0),
        .wr_dat_0 (wr_dat_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_word;

        reset    = 1'b0;
        strobe   = 1'b0;
        rd_enb_0 = 1'b1;
        rd_adr_0 = 5'd0;
        rd_enb_1 = 1'b1;
        rd_adr_1 = 5'd31;
        wr_enb_0 = 1'b0;
        wr_adr_0 = 5'd0;
        wr_dat_0 = 32'h0;

        // Reset held low across several edges
        repeat (2) tick();
        check("reset_rd0", rd_dat_0, 32'h0);
        check("reset_rd1", rd_dat_1, 32'h0);
        reset = 1'b1;

        // 1: both ports read addresses 0 and 31 after reset
        tick();
        check("t1_rd0_addr0", rd_dat_0, 32'h0);
        check("t1_rd1_addr31", rd_dat_1, 32'h0);

        // 2: write addr 1, then read it on each port
        rd_enb_0 = 1'b0;
        rd_enb_1 = 1'b0;
        wr_enb_0 = 1'b1;
        wr_adr_0 = 5'd1;
        wr_dat_0 = 32'h0000AAAA;
        tick();
        check("t2_disabled_rd0", rd_dat_0, 32'h0);
        wr_enb_0 = 1'b0;
        wr_dat_0 = 32'hFFFFFFFF;
        rd_enb_0 = 1'b1;
        rd_adr_0 = 5'd1;
        tick();
        check("t2_rd0_addr1", rd_dat_0, 32'h0000AAAA);
        rd_enb_0 = 1'b0;
        rd_enb_1 = 1'b1;
        rd_adr_1 = 5'd1;
        tick();
        check("t2_rd1_addr1", rd_dat_1, 32'h0000AAAA);
        check("t2_rd0_no_stale", rd_dat_0, 32'h0);

        // 3: independent addresses on the two ports
        rd_enb_1 = 1'b0;
        wr_enb_0 = 1'b1;
        wr_adr_0 = 5'd8;
        wr_dat_0 = 32'h00000008;
        tick();
        wr_enb_0 = 1'b0;
        rd_enb_0 = 1'b1;
        rd_adr_0 = 5'd8;
        rd_enb_1 = 1'b1;
        rd_adr_1 = 5'd1;
        tick();
        check("t3_rd0_addr8", rd_dat_0, 32'h00000008);
        check("t3_rd1_addr1", rd_dat_1, 32'h0000AAAA);

        // 4: write-first on the same edge, then disable
        rd_enb_1 = 1'b0;
        wr_enb_0 = 1'b1;
        wr_adr_0 = 5'd5;
        wr_dat_0 = 32'hDEADBEEF;
        rd_adr_0 = 5'd5;
        tick();
        check("t4_write_first", rd_dat_0, 32'hDEADBEEF);
        wr_enb_0 = 1'b0;
        rd_enb_0 = 1'b0;
        tick();
        check("t4_rd0_disabled", rd_dat_0, 32'h0);
        rd_enb_0 = 1'b1;
        rd_enb_1 = 1'b1;
        rd_adr_1 = 5'd5;
        tick();
        check("t4_same_addr_rd0", rd_dat_0, 32'hDEADBEEF);
        check("t4_same_addr_rd1", rd_dat_1, 32'hDEADBEEF);

        // 5: fill with ~addr and sweep both ports in opposite directions
        rd_enb_0 = 1'b0;
        rd_enb_1 = 1'b0;
        wr_enb_0 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wr_adr_0 = i[4:0];
            wr_dat_0 = ~i[31:0];
            tick();
        end
        wr_enb_0 = 1'b0;
        rd_enb_0 = 1'b1;
        rd_enb_1 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd_adr_0 = i[4:0];
            rd_adr_1 = 5'(31 - i);
            tick();
            exp_word = 32'hFFFFFFFF - i[31:0];
            check("t5_sweep_rd0", rd_dat_0, exp_word);
            exp_word = 32'hFFFFFFE0 + i[31:0];
            check("t5_sweep_rd1", rd_dat_1, exp_word);
        end

        // Reset asserted mid-sweep
        rd_adr_0 = 5'd10;
        rd_adr_1 = 5'd20;
        tick();
        check("t5_pre_reset_rd0", rd_dat_0, 32'hFFFFFFF5);
        check("t5_pre_reset_rd1", rd_dat_1, 32'hFFFFFFEB);
        #2;
        reset = 1'b0;
        #1;
        check("t5_reset_async_rd0", rd_dat_0, 32'h0);
        check("t5_reset_async_rd1", rd_dat_1, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("t5_reread_rd0", rd_dat_0, 32'h0);
        check("t5_reread_rd1", rd_dat_1, 32'h0);

        // 6: strobe behaviour on writes
        rd_enb_0 = 1'b0;
        rd_enb_1 = 1'b0;
        wr_enb_0 = 1'b1;
        wr_adr_0 = 5'd3;
        wr_dat_0 = 32'h12345678;
        strobe   = 1'b0;
        tick();
        wr_enb_0 = 1'b0;
        rd_enb_0 = 1'b1;
        rd_adr_0 = 5'd3;
        tick();
`ifdef STROBE_GATE_EN
        check("t6_strobe_low_blocked", rd_dat_0, 32'h0);
`else
        check("t6_strobe_ignored", rd_dat_0, 32'h12345678);
`endif
        rd_enb_0 = 1'b0;
        wr_enb_0 = 1'b1;
        wr_dat_0 = 32'h12345678;
        strobe   = 1'b1;
        tick();
        wr_enb_0 = 1'b0;
        strobe   = 1'b0;
        rd_enb_0 = 1'b1;
        tick();
        check("t6_strobe_high_commit", rd_dat_0, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
